// File: rtl/cpu_loader.sv
// cpu_loader: load / run / dump sequencer placed in front of the cpu top.
//
// Takes a 32-bit word stream (header, instruction words, data words, run
// length, dump length), writes the words into the cpu's instruction and data
// memories over the external ports, enables the cpu for the programmed number
// of cycles and then streams a region of data memory back out.
//
// Ports
//   clk, srst            clock, synchronous active-high reset
//   start                begin a session (honoured only in IDLE / DONE)
//   s_valid/s_ready/s_data   input word stream
//   m_valid/m_ready/m_data   dump word stream
//   imem_*               cpu addr_ext / wen_ext / ren_ext / wdata_ext
//   dmem_*               cpu addr_ext_2 / wen_ext_2 / ren_ext_2 / wdata_ext_2 / rdata_ext_2
//   cpu_enable           cpu enable, high only while running
//   busy, done           session status
module cpu_loader #(
   parameter int unsigned ADDR_STEP = 4,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic        clk,
   input  logic        srst,
   input  logic        start,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   output logic        s_ready,
   output logic        m_valid,
   output logic [31:0] m_data,
   input  logic        m_ready,
   output logic [31:0] imem_addr,
   output logic        imem_wen,
   output logic        imem_ren,
   output logic [31:0] imem_wdata,
   output logic [31:0] dmem_addr,
   output logic        dmem_wen,
   output logic        dmem_ren,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   output logic        cpu_enable,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0]  RdLat    = 8'(RD_LAT);
   localparam logic [31:0] AddrStep = 32'(ADDR_STEP);

   typedef enum logic [3:0] {
      StIdle, StHdr0, StLoadI, StLoadD, StHdrRun, StHdrDump, StRun, StDump, StDone
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] n_instr_q, n_instr_d;
   logic [15:0] n_data_q, n_data_d;
   logic [15:0] dump_words_q, dump_words_d;
   logic [15:0] idx_q, idx_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] run_left_q, run_left_d;
   logic [7:0]  lat_q, lat_d;
   logic        rd_pend_q, rd_pend_d;

   logic        s_ready_q, s_ready_d;
   logic        m_valid_q, m_valid_d;
   logic [31:0] m_data_q, m_data_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic        imem_wen_q, imem_wen_d;
   logic [31:0] imem_wdata_q, imem_wdata_d;
   logic [31:0] dmem_addr_q, dmem_addr_d;
   logic        dmem_wen_q, dmem_wen_d;
   logic        dmem_ren_q, dmem_ren_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic        cpu_enable_q, cpu_enable_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        accept;
   logic        enter_dump;

   assign accept = s_valid && s_ready_q;

   always_comb begin
      state_d      = state_q;
      n_instr_d    = n_instr_q;
      n_data_d     = n_data_q;
      dump_words_d = dump_words_q;
      idx_d        = idx_q;
      addr_d       = addr_q;
      run_left_d   = run_left_q;
      lat_d        = lat_q;
      rd_pend_d    = rd_pend_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      done_d       = done_q;
      // Memory strobes and addresses are single-cycle pulses, idle at 0.
      imem_addr_d  = '0;
      imem_wen_d   = 1'b0;
      imem_wdata_d = '0;
      dmem_addr_d  = '0;
      dmem_wen_d   = 1'b0;
      dmem_ren_d   = 1'b0;
      dmem_wdata_d = '0;
      cpu_enable_d = 1'b0;
      enter_dump   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) state_d = StHdr0;
         end
         StHdr0: begin
            if (accept) begin
               n_instr_d = s_data[31:16];
               n_data_d  = s_data[15:0];
               idx_d     = '0;
               addr_d    = '0;
               if (s_data[31:16] != '0)     state_d = StLoadI;
               else if (s_data[15:0] != '0) state_d = StLoadD;
               else                         state_d = StHdrRun;
            end
         end
         StLoadI: begin
            if (accept) begin
               imem_wen_d   = 1'b1;
               imem_addr_d  = addr_q;
               imem_wdata_d = s_data;
               idx_d        = idx_q + 16'd1;
               addr_d       = addr_q + AddrStep;
               if (idx_q == n_instr_q - 16'd1) begin
                  idx_d   = '0;
                  addr_d  = '0;
                  state_d = (n_data_q != '0) ? StLoadD : StHdrRun;
               end
            end
         end
         StLoadD: begin
            if (accept) begin
               dmem_wen_d   = 1'b1;
               dmem_addr_d  = addr_q;
               dmem_wdata_d = s_data;
               idx_d        = idx_q + 16'd1;
               addr_d       = addr_q + AddrStep;
               if (idx_q == n_data_q - 16'd1) begin
                  idx_d   = '0;
                  addr_d  = '0;
                  state_d = StHdrRun;
               end
            end
         end
         StHdrRun: begin
            if (accept) begin
               run_left_d = s_data;
               state_d    = StHdrDump;
            end
         end
         StHdrDump: begin
            if (accept) begin
               dump_words_d = s_data[15:0];
               if (run_left_q != '0) begin
                  state_d      = StRun;
                  cpu_enable_d = 1'b1;
               end else if (s_data[15:0] != '0) begin
                  enter_dump = 1'b1;
               end else begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
         end
         StRun: begin
            // State and cpu_enable are high together for exactly run_cycles cycles.
            run_left_d = run_left_q - 32'd1;
            if (run_left_q == 32'd1) begin
               if (dump_words_q != '0) begin
                  enter_dump = 1'b1;
               end else begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end else begin
               cpu_enable_d = 1'b1;
            end
         end
         StDump: begin
            if (rd_pend_q) begin
               // lat_q reaches 0 in the cycle where the read data is valid.
               if (lat_q == '0) begin
                  m_valid_d = 1'b1;
                  m_data_d  = dmem_rdata;
                  rd_pend_d = 1'b0;
               end else begin
                  lat_d = lat_q - 8'd1;
               end
            end else if (m_valid_q && m_ready) begin
               m_valid_d = 1'b0;
               if (idx_q == dump_words_q - 16'd1) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  idx_d       = idx_q + 16'd1;
                  addr_d      = addr_q + AddrStep;
                  dmem_ren_d  = 1'b1;
                  dmem_addr_d = addr_q + AddrStep;
                  rd_pend_d   = 1'b1;
                  lat_d       = RdLat;
               end
            end
         end
         StDone: begin
            if (start) begin
               state_d = StHdr0;
               done_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      // First read of the dump region, shared by the HDR_DUMP and RUN exits.
      if (enter_dump) begin
         state_d     = StDump;
         idx_d       = '0;
         addr_d      = '0;
         dmem_ren_d  = 1'b1;
         dmem_addr_d = '0;
         rd_pend_d   = 1'b1;
         lat_d       = RdLat;
      end

      busy_d    = !(state_d inside {StIdle, StDone});
      s_ready_d = state_d inside {StHdr0, StLoadI, StLoadD, StHdrRun, StHdrDump};
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q      <= StIdle;
         n_instr_q    <= '0;
         n_data_q     <= '0;
         dump_words_q <= '0;
         idx_q        <= '0;
         addr_q       <= '0;
         run_left_q   <= '0;
         lat_q        <= '0;
         rd_pend_q    <= 1'b0;
         s_ready_q    <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         imem_addr_q  <= '0;
         imem_wen_q   <= 1'b0;
         imem_wdata_q <= '0;
         dmem_addr_q  <= '0;
         dmem_wen_q   <= 1'b0;
         dmem_ren_q   <= 1'b0;
         dmem_wdata_q <= '0;
         cpu_enable_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_instr_q    <= n_instr_d;
         n_data_q     <= n_data_d;
         dump_words_q <= dump_words_d;
         idx_q        <= idx_d;
         addr_q       <= addr_d;
         run_left_q   <= run_left_d;
         lat_q        <= lat_d;
         rd_pend_q    <= rd_pend_d;
         s_ready_q    <= s_ready_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         imem_addr_q  <= imem_addr_d;
         imem_wen_q   <= imem_wen_d;
         imem_wdata_q <= imem_wdata_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wen_q   <= dmem_wen_d;
         dmem_ren_q   <= dmem_ren_d;
         dmem_wdata_q <= dmem_wdata_d;
         cpu_enable_q <= cpu_enable_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wen   = imem_wen_q;
   assign imem_ren   = 1'b0;
   assign imem_wdata = imem_wdata_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wen   = dmem_wen_q;
   assign dmem_ren   = dmem_ren_q;
   assign dmem_wdata = dmem_wdata_q;
   assign cpu_enable = cpu_enable_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_cpu_loader.sv
// Bench for cpu_loader: drives load/run/dump sessions with random words, gaps and
// dump back-pressure, and compares the observed memory traffic, enable window
// and dumped words against expectations derived from the session parameters.
module tb_cpu_loader;

   localparam int unsigned STEP   = 4;
   localparam int unsigned RD_LAT = 1;

   logic        clk = 1'b0;
   logic        srst, start, s_valid, s_ready, m_valid, m_ready;
   logic [31:0] s_data, m_data;
   logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata, dmem_rdata;
   logic        imem_wen, imem_ren, dmem_wen, dmem_ren, cpu_enable, busy, done;

   cpu_loader #(.ADDR_STEP(STEP), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .srst(srst), .start(start),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren),
      .imem_wdata(imem_wdata),
      .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .cpu_enable(cpu_enable), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Data memory stand-in with a fixed read latency; garbage outside the valid slot.
   logic [31:0] phys [256];
   logic [31:0] rpipe [RD_LAT];
   always @(posedge clk) begin
      if (dmem_wen) phys[dmem_addr[9:2]] <= dmem_wdata;
      rpipe[0] <= dmem_ren ? phys[dmem_addr[9:2]] : 32'hDEAD_BEEF;
      for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign dmem_rdata = rpipe[RD_LAT-1];

   // Reference contents of data memory, updated from the words the bench sends.
   logic [31:0] model_mem [256];
   int          dm_hw = 0;

   int nvec = 0;
   int nfail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: logs traffic and counts protocol violations mid-cycle.
   logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$], rd_a[$], dump_d[$];
   int          cyc = 0, en_cnt = 0, en_rises = 0, en_first = 0, en_last = 0, viol = 0;
   int          outstanding = 0;
   bit          hold_prev = 0, en_prev = 0;
   logic [31:0] prev_data = '0;

   always @(negedge clk) begin
      cyc++;
      if (imem_wen) begin iw_a.push_back(imem_addr); iw_d.push_back(imem_wdata); end
      if (dmem_wen) begin dw_a.push_back(dmem_addr); dw_d.push_back(dmem_wdata); end
      if (cpu_enable) begin
         if (!en_prev) begin en_rises++; en_first = cyc; end
         en_last = cyc;
         en_cnt++;
      end
      en_prev = cpu_enable;
      if (imem_ren) viol++;
      if (cpu_enable && (imem_wen || dmem_wen || dmem_ren)) viol++;
      if (dmem_wen && dmem_ren) viol++;
      if (dmem_ren) begin
         if (outstanding != 0 || m_valid) viol++;
         outstanding = 1;
         rd_a.push_back(dmem_addr);
      end
      if (hold_prev && (!m_valid || m_data !== prev_data)) viol++;
      if (m_valid && m_ready) begin dump_d.push_back(m_data); outstanding = 0; end
      hold_prev = m_valid && !m_ready;
      prev_data = m_data;
      if (srst) begin outstanding = 0; hold_prev = 0; end
   end

   // m_ready pattern: 0 always ready, 1 toggling, 2 random.
   int mr_mode = 0;
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (mr_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(1, 0));
         endcase
      end
   end

   logic [31:0] ins_w [16];
   logic [31:0] dat_w [16];

   task automatic send_word(input logic [31:0] w, input int gap, input bit poke);
      bit rdy = 0;
      int budget = 2000;
      s_valid = 1'b1;
      s_data  = w;
      if (poke) start = 1'b1;
      do begin
         rdy = s_ready;
         @(posedge clk); #1;
         budget--;
      end while (!rdy && budget > 0);
      start   = 1'b0;
      s_valid = 1'b0;
      if (!rdy) check_eq("accept_timeout", 32'(rdy), 32'd1);
      repeat (gap) begin
         s_data = $urandom;
         @(posedge clk); #1;
      end
   endtask

   task automatic run_session(input int n_i, input int n_d, input logic [31:0] run_cyc,
                              input int n_dump, input int gap, input int mode,
                              input bit poke, input bit abort);
      int  iw0 = iw_a.size(), dw0 = dw_a.size(), rd0 = rd_a.size(), du0 = dump_d.size();
      int  en0 = en_cnt, er0 = en_rises, v0 = viol;
      bit  poked = 0;
      mr_mode = mode;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("start_s_ready", 32'(s_ready), 32'd1);
      check_eq("start_done", 32'(done), 32'd0);
      check_eq("start_busy", 32'(busy), 32'd1);

      send_word({16'(n_i), 16'(n_d)}, gap, 1'b0);
      for (int k = 0; k < n_i; k++) send_word(ins_w[k], gap, poke && k == 1);
      for (int k = 0; k < n_d; k++) begin
         send_word(dat_w[k], gap, 1'b0);
         model_mem[k] = dat_w[k];
      end
      if (n_d > dm_hw) dm_hw = n_d;
      send_word(run_cyc, gap, 1'b0);
      send_word(32'(n_dump), gap, 1'b0);

      if (abort) begin
         // Now in RUN cycle 1; assert srst during RUN cycle 5.
         repeat (4) begin @(posedge clk); #1; end
         srst = 1'b1;
         @(posedge clk); #1;
         srst = 1'b0;
         check_eq("rst_cpu_enable", 32'(cpu_enable), 32'd0);
         check_eq("rst_busy", 32'(busy), 32'd0);
         check_eq("rst_done", 32'(done), 32'd0);
         check_eq("rst_s_ready", 32'(s_ready), 32'd0);
         @(negedge clk);
         check_eq("rst_en_cycles", 32'(en_cnt - en0), 32'd5);
         return;
      end

      for (int c = 0; c < 5000 && !done; c++) begin
         start = poke && !poked && m_valid;
         if (start) poked = 1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check_eq("done", 32'(done), 32'd1);
      check_eq("idle_busy", 32'(busy), 32'd0);
      @(negedge clk);

      check_eq("imem_nwr", 32'(iw_a.size() - iw0), 32'(n_i));
      for (int k = 0; k < n_i && iw0 + k < iw_a.size(); k++) begin
         check_eq("imem_addr", iw_a[iw0+k], 32'(k * STEP));
         check_eq("imem_data", iw_d[iw0+k], ins_w[k]);
      end
      check_eq("dmem_nwr", 32'(dw_a.size() - dw0), 32'(n_d));
      for (int k = 0; k < n_d && dw0 + k < dw_a.size(); k++) begin
         check_eq("dmem_addr", dw_a[dw0+k], 32'(k * STEP));
         check_eq("dmem_data", dw_d[dw0+k], dat_w[k]);
      end
      check_eq("en_cycles", 32'(en_cnt - en0), run_cyc);
      check_eq("en_windows", 32'(en_rises - er0), 32'(run_cyc != 0));
      if (run_cyc != 0) check_eq("en_contig", 32'(en_last - en_first + 1), run_cyc);
      check_eq("n_reads", 32'(rd_a.size() - rd0), 32'(n_dump));
      check_eq("n_dumped", 32'(dump_d.size() - du0), 32'(n_dump));
      for (int k = 0; k < n_dump && du0 + k < dump_d.size() && rd0 + k < rd_a.size(); k++) begin
         check_eq("rd_addr", rd_a[rd0+k], 32'(k * STEP));
         check_eq("dump_word", dump_d[du0+k], model_mem[k]);
      end
      check_eq("protocol", 32'(viol - v0), 32'd0);
   endtask

   initial begin
      srst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) begin @(posedge clk); #1; end
      srst = 1'b0;
      check_eq("rst_s_ready", 32'(s_ready), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_enable", 32'(cpu_enable), 32'd0);
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_strobes", 32'({imem_wen, imem_ren, dmem_wen, dmem_ren}), 32'd0);
      check_eq("rst_addrs", imem_addr | dmem_addr | m_data, 32'd0);

      // Load only, no run, no dump.
      for (int k = 0; k < 3; k++) ins_w[k] = $urandom;
      for (int k = 0; k < 2; k++) dat_w[k] = $urandom;
      run_session(3, 2, 32'd0, 0, 0, 0, 1'b0, 1'b0);

      // One instruction, run 10 cycles, dump one word.
      ins_w[0] = 32'h2001_0005;
      run_session(1, 0, 32'd10, 1, 0, 0, 1'b0, 1'b0);

      // Four data words dumped under toggling m_ready.
      dat_w[0] = 32'h11; dat_w[1] = 32'h22; dat_w[2] = 32'h33; dat_w[3] = 32'h44;
      run_session(0, 4, 32'd3, 4, 0, 1, 1'b0, 1'b0);

      // Three-cycle gaps between stream words.
      for (int k = 0; k < 3; k++) begin ins_w[k] = $urandom; dat_w[k] = $urandom; end
      run_session(3, 3, 32'd5, 3, 3, 2, 1'b0, 1'b0);

      // Reset in RUN, then a fresh complete session.
      run_session(2, 2, 32'd20, 2, 0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin ins_w[k] = $urandom; dat_w[k] = $urandom; end
      run_session(2, 4, 32'd4, 4, 1, 0, 1'b0, 1'b0);

      // start pulsed during LOAD_I and DUMP must be ignored.
      for (int k = 0; k < 3; k++) begin ins_w[k] = $urandom; dat_w[k] = $urandom; end
      run_session(3, 2, 32'd2, 3, 0, 1, 1'b1, 1'b0);

      for (int s = 0; s < 4; s++) begin
         int ni = $urandom_range(5, 0);
         int nd = $urandom_range(5, 0);
         for (int k = 0; k < ni; k++) ins_w[k] = $urandom;
         for (int k = 0; k < nd; k++) dat_w[k] = $urandom;
         run_session(ni, nd, 32'($urandom_range(12, 0)),
                     $urandom_range((nd > dm_hw) ? nd : dm_hw, 0),
                     $urandom_range(2, 0), $urandom_range(2, 0), 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
